// File: rtl/dout_pkg.sv
// Shared definitions for the float-to-fix result write port.
// Holds the beat field widths, the sequence and app codes, the arbiter
// state enum and small helpers that build a beat and validate a result.
package dout_pkg;

   localparam int APP_W  = 2;
   localparam int SIZE_W = 3;
   localparam int SEQ_W  = 3;
   localparam int PAY_W  = 40;
   localparam int BEAT_W = APP_W + SIZE_W + SEQ_W + PAY_W;

   localparam logic [SEQ_W-1:0] SEQ_ONLY   = 3'b000;
   localparam logic [SEQ_W-1:0] SEQ_FIRST  = 3'b001;
   localparam logic [SEQ_W-1:0] SEQ_SECOND = 3'b010;

   localparam logic [APP_W-1:0] APP_FIX = 2'd1;
   localparam logic [APP_W-1:0] APP_FLT = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      BEAT1,
      BEAT2
   } state_t;

   // Header-tagged output word: app, size and seq ahead of a 40-bit slice.
   function automatic logic [BEAT_W-1:0] make_beat(
      input logic [APP_W-1:0]  app,
      input logic [SIZE_W-1:0] size,
      input logic [SEQ_W-1:0]  seq,
      input logic [PAY_W-1:0]  pay
   );
      return {app, size, seq, pay};
   endfunction

   // Only fixed/float apps with sizes 1..3 turn into beats.
   function automatic logic is_well_formed(
      input logic [APP_W-1:0]  app,
      input logic [SIZE_W-1:0] size
   );
      return ((app == APP_FIX) || (app == APP_FLT)) &&
             (size >= 3'd1) && (size <= 3'd3);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker over NUM_REQ request lines.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   req       request vector, one bit per lane
//   advance   the caller is taking the current pick this cycle
//   grant     one-hot pick (zero when no lane requests)
//   idx       binary index of the pick
// The pointer remembers the last lane taken; the search starts one past
// it, and it resets to the top lane so lane 0 wins first.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] pos;
   logic             found;

   // Walk the lanes starting one past the pointer and keep the first hit.
   always_comb begin
      grant = '0;
      idx   = '0;
      pos   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

   // The pointer only moves when a pick is actually taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= IDX_W'(NUM_REQ - 1);
      end else if (advance && found) begin
         ptr <= idx;
      end
   end

endmodule

// File: rtl/dout_arbiter.sv
// Shares the 48-bit result write port between NUM_REQ converter lanes.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   req_valid    lane i holds a finished result
//   req_app      per-lane 2-bit app code (1 fixed, 2 float)
//   req_size     per-lane 3-bit size code (1 = one beat, 2/3 = two beats)
//   req_payload  per-lane 80-bit payload, left aligned
//   req_ready    one-hot, lane i's result is taken this cycle
//   fifo_full    downstream FIFO cannot take a write this cycle
//   dataout      registered beat to the FIFO (zero when not writing)
//   wren         registered write strobe
//   drop_cnt     saturating count of malformed results thrown away
// The state names the beat currently pending or being written; wren high
// in BEAT1/BEAT2 means that beat is written in this cycle.
module dout_arbiter
   import dout_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PAYLOAD = 80,
   parameter int DATAOUT = 48
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [2*NUM_REQ-1:0]       req_app,
   input  logic [3*NUM_REQ-1:0]       req_size,
   input  logic [PAYLOAD*NUM_REQ-1:0] req_payload,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       fifo_full,
   output logic [DATAOUT-1:0]         dataout,
   output logic                       wren,
   output logic [7:0]                 drop_cnt
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t              state;
   logic                two_beat;
   logic [APP_W-1:0]    app_q;
   logic [SIZE_W-1:0]   size_q;
   logic [PAYLOAD-1:0]  pay_q;

   logic [NUM_REQ-1:0]  grant;
   logic [IDX_W-1:0]    idx;
   logic                final_write;
   logic                grant_ok;
   logic                took;
   logic [APP_W-1:0]    sel_app;
   logic [SIZE_W-1:0]   sel_size;
   logic [PAYLOAD-1:0]  sel_pay;
   logic                sel_ok;
   logic                sel_two;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (grant_ok),
      .grant   (grant),
      .idx     (idx)
   );

   // A new packet may start when idle or while the last beat of the current
   // one is being written, which lets packets run back to back.
   always_comb begin
      final_write = wren && ((state == BEAT2) || ((state == BEAT1) && !two_beat));
      grant_ok    = (state == IDLE) || final_write;
      took        = grant_ok && (|req_valid);
      req_ready   = grant_ok ? grant : '0;
   end

   // Fields of the lane the arbiter is pointing at.
   always_comb begin
      sel_app  = req_app[int'(idx)*APP_W +: APP_W];
      sel_size = req_size[int'(idx)*SIZE_W +: SIZE_W];
      sel_pay  = req_payload[int'(idx)*PAYLOAD +: PAYLOAD];
      sel_ok   = is_well_formed(sel_app, sel_size);
      sel_two  = (sel_size != 3'd1);
   end

   // Packet FSM with registered outputs. The case advances the packet in
   // flight; a grant taken this cycle is evaluated afterwards and overrides
   // it, which is safe because a grant only happens once nothing is pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         two_beat <= 1'b0;
         app_q    <= '0;
         size_q   <= '0;
         pay_q    <= '0;
         wren     <= 1'b0;
         dataout  <= '0;
         drop_cnt <= '0;
      end else begin
         wren    <= 1'b0;
         dataout <= '0;

         case (state)
            BEAT1: begin
               if (wren) begin
                  if (two_beat) begin
                     state <= BEAT2;
                     if (!fifo_full) begin
                        wren    <= 1'b1;
                        dataout <= DATAOUT'(make_beat(app_q, size_q, SEQ_SECOND,
                                                      pay_q[PAYLOAD-PAY_W-1 -: PAY_W]));
                     end
                  end else begin
                     state <= IDLE;
                  end
               end else if (!fifo_full) begin
                  wren    <= 1'b1;
                  dataout <= DATAOUT'(make_beat(app_q, size_q,
                                                two_beat ? SEQ_FIRST : SEQ_ONLY,
                                                pay_q[PAYLOAD-1 -: PAY_W]));
               end
            end
            BEAT2: begin
               if (wren) begin
                  state <= IDLE;
               end else if (!fifo_full) begin
                  wren    <= 1'b1;
                  dataout <= DATAOUT'(make_beat(app_q, size_q, SEQ_SECOND,
                                                pay_q[PAYLOAD-PAY_W-1 -: PAY_W]));
               end
            end
            default: begin
            end
         endcase

         if (took) begin
            if (sel_ok) begin
               state    <= BEAT1;
               two_beat <= sel_two;
               app_q    <= sel_app;
               size_q   <= sel_size;
               pay_q    <= sel_pay;
               if (!fifo_full) begin
                  wren    <= 1'b1;
                  dataout <= DATAOUT'(make_beat(sel_app, sel_size,
                                                sel_two ? SEQ_FIRST : SEQ_ONLY,
                                                sel_pay[PAYLOAD-1 -: PAY_W]));
               end
            end else begin
               state <= IDLE;
               if (drop_cnt != 8'hFF) begin
                  drop_cnt <= drop_cnt + 8'd1;
               end
            end
         end
      end
   end

endmodule
